// File: rtl/seg7_scan6.sv
// Six-digit multiplexed seven-segment scan driver: frame-atomic snapshot of
// BCD digits/decimal points with optional leading-zero blanking.
module seg7_scan6 #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] digits_in,
   input  logic [5:0]  dp_in,
   input  logic        blank_en,
   output logic [2:0]  seg7_sel,
   output logic [6:0]  seg7_out,
   output logic        dpt_out,
   output logic        frame_start
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   snap_dig_q;
   logic [5:0]    snap_dp_q, blank_q;
   logic [2:0]    sel_q;
   logic [6:0]    seg_q;
   logic          dpt_q, fs_q;

   logic          tick, wrap;
   logic [5:0]    zero_up, blank_new;
   logic [23:0]   eff_dig;
   logic [5:0]    eff_dp, eff_blank;
   logic [3:0]    cur_dig;
   logic [6:0]    cur_seg;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'b1111110;
         4'd1:    dec7 = 7'b0110000;
         4'd2:    dec7 = 7'b1101101;
         4'd3:    dec7 = 7'b1111001;
         4'd4:    dec7 = 7'b0110011;
         4'd5:    dec7 = 7'b1011011;
         4'd6:    dec7 = 7'b1011111;
         4'd7:    dec7 = 7'b1110000;
         4'd8:    dec7 = 7'b1111111;
         4'd9:    dec7 = 7'b1111011;
         default: dec7 = 7'b0000001;
      endcase
   endfunction

   assign tick = (cnt_q == CW'(SCAN_DIV - 1));
   assign wrap = tick && (idx_q == 3'd5);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
   end

   // zero_up[k]: digits k..5 of the live inputs are all zero
   always_comb begin
      zero_up[5] = (digits_in[23:20] == 4'h0);
      for (int k = 4; k >= 0; k--)
         zero_up[k] = zero_up[k+1] & (digits_in[4*k +: 4] == 4'h0);
      blank_new = {zero_up[5:1] & {5{blank_en}}, 1'b0};
   end

   // On the snapshot edge digit 0 is taken straight from the inputs
   always_comb begin
      eff_dig   = wrap ? digits_in : snap_dig_q;
      eff_dp    = wrap ? dp_in     : snap_dp_q;
      eff_blank = wrap ? blank_new : blank_q;
      cur_dig   = eff_dig[{idx_d, 2'b00} +: 4];
      cur_seg   = eff_blank[idx_d] ? 7'b0000000 : dec7(cur_dig);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= 3'd5;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         blank_q    <= '0;
         sel_q      <= 3'd0;
         seg_q      <= 7'd0;
         dpt_q      <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         fs_q  <= wrap;
         if (wrap) begin
            snap_dig_q <= digits_in;
            snap_dp_q  <= dp_in;
            blank_q    <= blank_new;
         end
         if (tick) begin
            sel_q <= 3'd5 - idx_d;
            seg_q <= cur_seg;
            dpt_q <= eff_dp[idx_d];
         end
      end
   end

   assign seg7_sel    = sel_q;
   assign seg7_out    = seg_q;
   assign dpt_out     = dpt_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan6.sv
// Directed bench for seg7_scan6 at SCAN_DIV=4: reset timing, scan order,
// blanking, dash decode, decimal points, frame snapshot and mid-frame reset.
module tb_seg7_scan6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] digits_in = '0;
   logic [5:0]  dp_in = '0;
   logic        blank_en = 1'b0;
   logic [2:0]  seg7_sel;
   logic [6:0]  seg7_out;
   logic        dpt_out;
   logic        frame_start;

   int n_chk = 0;
   int n_pass = 0;

   logic [6:0] SEG [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

   seg7_scan6 #(.SCAN_DIV(4)) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
      .blank_en(blank_en), .seg7_sel(seg7_sel), .seg7_out(seg7_out),
      .dpt_out(dpt_out), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, " sel"}, 32'(seg7_sel), 32'd0);
      chk({tag, " seg"}, 32'(seg7_out), 32'd0);
      chk({tag, " dp"},  32'(dpt_out), 32'd0);
      chk({tag, " fs"},  32'(frame_start), 32'd0);
   endtask

   // Entered just after a frame_start edge; checks 24 cycles and leaves just
   // after the next frame_start edge. New inputs go in two cycles in.
   task automatic check_frame(input string tag, input logic [23:0] ed,
                              input logic [5:0] eblank, input logic [5:0] edp,
                              input logic [23:0] nd, input logic [5:0] ndp,
                              input logic nbe);
      for (int c = 0; c < 24; c++) begin
         int i;
         logic [3:0] d;
         i = c / 4;
         d = ed[4*i +: 4];
         chk($sformatf("%s c%0d sel", tag, c), 32'(seg7_sel), 32'(5 - i));
         chk($sformatf("%s c%0d seg", tag, c), 32'(seg7_out),
             eblank[i] ? 32'd0 : 32'(SEG[d]));
         chk($sformatf("%s c%0d dp", tag, c), 32'(dpt_out), 32'(edp[i]));
         chk($sformatf("%s c%0d fs", tag, c), 32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
         if (c == 2) begin
            digits_in = nd;
            dp_in     = ndp;
            blank_en  = nbe;
         end
         step();
      end
   endtask

   task automatic reset_release_seq(input string tag, input logic [6:0] exp_seg0);
      for (int e = 1; e <= 3; e++) begin
         step();
         chk_dark($sformatf("%s edge%0d", tag, e));
      end
      step();
      chk({tag, " e4 sel"}, 32'(seg7_sel), 32'd5);
      chk({tag, " e4 seg"}, 32'(seg7_out), 32'(exp_seg0));
      chk({tag, " e4 fs"},  32'(frame_start), 32'd1);
   endtask

   initial begin
      digits_in = 24'h123456;
      #1;
      chk_dark("in reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      reset_release_seq("rst1", 7'b1011111);

      check_frame("f123456", 24'h123456, 6'b000000, 6'b0, 24'h000090, 6'b0, 1'b1);
      check_frame("f000090", 24'h000090, 6'b111100, 6'b0, 24'h000000, 6'b0, 1'b1);
      check_frame("f000000", 24'h000000, 6'b111110, 6'b0, 24'h111111, 6'b0, 1'b0);
      check_frame("f111111", 24'h111111, 6'b000000, 6'b0, 24'h222222, 6'b0, 1'b0);
      check_frame("f222222", 24'h222222, 6'b000000, 6'b0, 24'h0000A0, 6'b000100, 1'b1);
      check_frame("f0000A0", 24'h0000A0, 6'b111100, 6'b000100, 24'h0000A0, 6'b000100, 1'b1);

      // advance to the digit shown at sel=2 and hit reset there
      repeat (12) step();
      chk("pre-reset sel", 32'(seg7_sel), 32'd2);
      reset = 1'b1;
      #1;
      chk_dark("mid reset");
      repeat (2) @(posedge clk);
      #1;
      chk_dark("held reset");
      reset = 1'b0;
      reset_release_seq("rst2", 7'b1111110);
      step();
      chk("rst2 e5 fs", 32'(frame_start), 32'd0);
      chk("rst2 e5 sel", 32'(seg7_sel), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seg7_scan6.md
# seg7_scan6

Six-digit multiplexed seven-segment scan driver. It sits downstream of the BCD counter stages (count_0_9 and wider chains). It takes six packed BCD digits plus per-digit decimal-point flags and time-multiplexes them onto the board's shared segment bus and 3-bit digit select. It replaces the fixed single-digit select and standalone bcd_to_seg7 in top-level wrappers once more than one digit must be shown.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays selected; legal range 2..2^20.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  24  packed BCD; digit i = digits_in[4i+3:4i], i=0 least significant.
- dp_in  in  6  bit i lights the decimal point of digit i.
- blank_en  in  1  1 = leading-zero blanking enabled.
- seg7_sel  out  3  binary select of the active display position; digit i is shown when seg7_sel = 5-i.
- seg7_out  out  7  segments {a,b,c,d,e,f,g} on [6:0], 1 = lit.
- dpt_out  out  1  decimal point, 1 = lit.
- frame_start  out  1  one-cycle pulse on the edge where digit 0 becomes active.

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. tick = (cnt == SCAN_DIV-1).
- Digit index idx (0..5) advances on each tick: idx → idx+1, with 5 → 0.
- Frame snapshot is taken on the tick where idx wraps 5→0:
  - digits_in, dp_in, and a 6-bit blank mask are registered.
  - Inputs are ignored at all other times, so the display never tears mid-frame.
- Blank mask, computed at snapshot from the sampled inputs:
  - Digit k (k=5..1) is blanked iff blank_en=1 and digits k..5 are all 4'h0.
  - Digit 0 is never blanked.
- Decode, digits 0-9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
- Decode, codes 10-15: 0000001 (dash).
- A blanked digit drives seg7_out=0000000. dpt_out still follows its dp bit.
- seg7_sel, seg7_out, dpt_out and frame_start are all registered and change on the same edge.
- On the snapshot edge, the digit-0 outputs use the inputs sampled on that edge (bypass), not the previous snapshot.

## Timing
- Reset (async, immediate):
  - cnt=0, idx=5, snapshot=0, blank mask=0.
  - seg7_sel=3'b000, seg7_out=7'b0000000, dpt_out=0, frame_start=0.
- After reset release, the first tick occurs on the SCAN_DIV-th rising edge. On that edge:
  - idx becomes 0 and the snapshot loads.
  - seg7_sel=3'b101 and digit-0 segments appear.
  - frame_start=1 for that one cycle.
- Each digit is held exactly SCAN_DIV cycles. Frame period is 6*SCAN_DIV cycles. frame_start has exactly that period.
- Until the first tick, outputs hold their reset values (dark display).
- Input change on the snapshot edge itself: the value sampled on that edge is used.
- Input change on any other edge: takes effect at the next frame.
- Reset asserted mid-frame: outputs return to reset values at once. Scanning restarts as from power-up.
- Counter width: enough to hold SCAN_DIV-1. No other arithmetic.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset release: outputs stay 000/0000000/0 for 3 edges. On the 4th edge: seg7_sel=5, seg7_out equals decode of digits_in[3:0], frame_start=1 for one cycle.
- digits_in=24'h123456, dp_in=0, blank_en=0:
  - seg7_sel steps 5,4,3,2,1,0 showing 6,5,4,3,2,1, each for 4 cycles.
  - frame_start pulses every 24 cycles.
- digits_in=24'h000090, blank_en=1:
  - sel 5 → 1111110, sel 4 → 1111011, sel 3..0 → 0000000.
  - With digits_in=0, only sel 5 shows 1111110.
- Snapshot: set 24'h111111, then change to 24'h222222 two cycles after frame_start. The display shows 1s for the remainder of the frame and 2s from the next frame_start.
- digits_in[7:4]=4'hA gives 0000001 at sel 4. dp_in=6'b000100 gives dpt_out=1 only while sel=3, including when digit 2 is blanked.
- Assert reset while sel=2: all outputs go to 000/0000000/0 immediately. After release, the scenario-1 timing repeats exactly.
